// File: rtl/alu_pkg.sv
// ALU control codes and operand-width default, shared between the operand stage and the ALU.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/reg_file.sv
// Register file: two combinational read ports with write-port bypass, one write port, x0 reads zero.
// Read latency zero; write lands on the rising clock edge.
module reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREG];
  logic            wr_live;

  assign wr_live = we && (waddr != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[waddr] <= wdata;
    end
  end

  // x0 check comes first so a write to x0 can never be forwarded either.
  always_comb begin
    rdata1 = mem[raddr1];
    if (raddr1 == 5'd0)                   rdata1 = '0;
    else if (wr_live && waddr == raddr1)  rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (raddr2 == 5'd0)                   rdata2 = '0;
    else if (wr_live && waddr == raddr2)  rdata2 = wdata;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: reads sources, picks imm or rs2, registers one instruction for the ALU (1-cycle latency).
// Holds the snapshot while out_ready is low; in_ready drops when full and stalled or on flush.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [3:0]      alu_op,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic [3:0]      ALUc,
  output logic [4:0]      out_rd,
  output logic            err_illegal
);

  stage_state_t    state;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic            accept;

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rf_rd1),
    .rdata2 (rf_rd2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  // Flush wins over everything; otherwise accept reloads, a bare consume empties, a stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      data1       <= '0;
      data2       <= '0;
      ALUc        <= 4'b0000;
      out_rd      <= 5'd0;
      err_illegal <= 1'b0;
    end else begin
      if (flush) begin
        state <= ST_EMPTY;
      end else if (accept) begin
        state  <= ST_FULL;
        data1  <= rf_rd1;
        data2  <= use_imm ? imm : rf_rd2;
        ALUc   <= alu_op;
        out_rd <= rd;
        if (!is_legal_op(alu_op)) err_illegal <= 1'b1;
      end else if (out_ready) begin
        state <= ST_EMPTY;
      end
    end
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and register width.
REQ-002 SHALL have parameter NREG, default 32, the register count; register index width is 5.
REQ-003 SHALL have one clock and one reset: clk is the single clock, rising edge; rst_n is the asynchronous, active-low reset.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  decoded instruction present.
REQ-007 in_ready  output  1  stage can accept.
REQ-008 rs1, rs2, rd  input  5 each  source and destination register indices.
REQ-009 imm  input  XLEN  immediate operand.
REQ-010 use_imm  input  1  selects imm as second operand.
REQ-011 alu_op  input  4  ALU control code.
REQ-012 wb_en, wb_addr, wb_data  input  1/5/XLEN  write-back port.
REQ-013 flush  input  1  discard held and incoming instruction.
REQ-014 out_valid  output  1  operands valid for ALU.
REQ-015 out_ready  input  1  ALU side consumes.
REQ-016 data1, data2  output  XLEN each  ALU operands.
REQ-017 ALUc  output  4  ALU control.
REQ-018 out_rd  output  5  destination index.
REQ-019 err_illegal  output  1  sticky illegal-op flag.

Function
REQ-020 Register file: NREG x XLEN, two combinational read ports, one write port written on rising clk when wb_en=1 and wb_addr!=0.
REQ-021 Register 0 SHALL always read 0; writes to it are ignored.
REQ-022 Write bypass: when wb_en=1, wb_addr!=0 and wb_addr equals rs1/rs2 in the same cycle, the read SHALL return wb_data.
REQ-023 in_ready = !flush && (!out_valid || out_ready).
REQ-024 Accept on in_valid && in_ready: next cycle data1=RF[rs1], data2=use_imm ? imm : RF[rs2], ALUc=alu_op, out_rd=rd, out_valid=1; latency one cycle.
REQ-025 out_valid && out_ready with no new accept: out_valid clears next cycle.
REQ-026 Simultaneous consume and accept: new instruction loads, out_valid stays 1 (full throughput, no bubble).
REQ-027 out_valid && !out_ready: data1, data2, ALUc, out_rd SHALL hold stable; operands are a snapshot and SHALL NOT update on later write-back.
REQ-028 flush=1: out_valid=0 next cycle, no acceptance that cycle; flush overrides in_valid and out_ready.
REQ-029 Legal codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-030 Accepted illegal code: passed through unchanged and err_illegal set to 1, held until reset.
REQ-031 State: EMPTY (out_valid=0), FULL (out_valid=1); EMPTY->FULL on accept; FULL->EMPTY on consume without accept or on flush; FULL->FULL on stall or consume-with-accept.

Reset
REQ-032 rst_n low asynchronously: out_valid=0, data1=0, data2=0, ALUc=0000, out_rd=0, err_illegal=0, all registers 0.
REQ-033 Reset mid-stall SHALL drop the held instruction; in_ready=1 the first cycle after release.

Structure
REQ-034 Shared package alu_pkg SHALL hold the six ALUc code constants and XLEN default, shared with the ALU.
REQ-035 Register file SHALL be one sub-module, reg_file (two read, one write, x0 hardwired, bypass).
REQ-036 Handshake register and legality check SHALL reside in alu_operand_stage.

Verification
REQ-037 Write RF[1]=5, RF[2]=7; issue rs1=1, rs2=2, alu_op=0010 -> next cycle out_valid=1, data1=5, data2=7, ALUc=0010.
REQ-038 wb_en=1, wb_addr=3, wb_data=6 same cycle as issue rs1=3, use_imm=1, imm=2, alu_op=0110 -> data1=6, data2=2, ALUc=0110.
REQ-039 out_ready=0 three cycles with write to held rs1 -> in_ready=0, outputs unchanged; out_ready=1 -> next queued instruction appears one cycle later.
REQ-040 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not accepted.
REQ-041 Write wb_addr=0 data 0xFFFFFFFF; issue rs1=0, rs2=0, alu_op=0111 -> data1=0, data2=0.
REQ-042 Issue alu_op=1111 -> ALUc=1111, err_illegal=1 persists until rst_n low, then 0.
